xor_stream_decrypt: RTL
=======================

# xor_stream_decrypt

Receive-side counterpart of the XOR cipher datapath: it consumes the serial ciphertext stream (data bit plus start/end frame flags) and strips the repeating key on the fly. Output is plaintext as a byte stream with a one-cycle valid strobe, and frame errors are flagged. The key is loaded over a one-bit serial input qualified by a load flag. The block sits at the far end of the ciphertext serial link, on the verification board or host-side fabric, and lets the encryptor be checked end to end.

## Interface
- KEY_SIZE, 32, key length in bits; power of two, ≥ 8
- MSG_SIZE, 512, frame length in bits; multiple of 8 and of KEY_SIZE
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  synchronous, active-low reset
- ena  in  1  clock enable; low freezes all state, and all output strobes are forced low
- iKey_bit  in  1  serial key data
- iLoad_key  in  1  key bit qualifier; one key bit sampled per cycle while high
- iSerial_in  in  1  ciphertext data bit
- iSerial_start  in  1  frame start; high in the cycle of frame bit 0
- iSerial_end  in  1  frame end; high in the cycle of frame bit MSG_SIZE-1
- oByte  out  8  plaintext byte; frame bit 8k is at oByte[0]
- oByte_valid  out  1  one-cycle strobe, oByte valid
- oFrame_done  out  1  one-cycle strobe, frame completed cleanly
- oFrame_err  out  1  one-cycle strobe, protocol error
- oKey_ready  out  1  a full key has been loaded since reset
- oBusy  out  1  high while in RECV

## Operation
- Key register
  - KEY_SIZE-bit shift register, LSB first: key <= {iKey_bit, key[KEY_SIZE-1:1]}.
  - Shifts only when iLoad_key=1 and state=IDLE. iLoad_key in RECV is ignored and the key stays frozen for the frame.
  - Key counter saturates at KEY_SIZE. oKey_ready=1 once the count reaches KEY_SIZE.
  - Extra load bits keep shifting, so the last KEY_SIZE bits win.
- States: IDLE, RECV.
- IDLE → RECV when iSerial_start=1 and oKey_ready=1.
  - The start-cycle bit is frame bit 0 and is processed.
  - Bit counter := 1.
- In IDLE, iSerial_start=1 with oKey_ready=0 → stay in IDLE and pulse oFrame_err.
- IDLE also ignores iSerial_in and iSerial_end.
- RECV, each cycle:
  - Plain bit p = iSerial_in ^ key[i mod KEY_SIZE], where i is the frame bit index.
  - p is shifted into the byte shift register: byte <= {p, byte[7:1]}.
  - Bit counter increments.
- Byte emit: when (i mod 8)=7, the completed byte is registered to oByte and oByte_valid=1 the next cycle.
- Clean end: iSerial_end=1 with i=MSG_SIZE-1.
  - Last byte is emitted.
  - oFrame_done=1 in the same cycle as that byte's oByte_valid.
  - → IDLE.
- Short frame: iSerial_end=1 with i<MSG_SIZE-1.
  - Partial byte is discarded; no oByte_valid for it.
  - oFrame_err pulse; → IDLE.
- Overlong frame: i=MSG_SIZE-1 and iSerial_end=0.
  - Last byte is still emitted.
  - oFrame_err pulses in place of oFrame_done; → IDLE.
  - Following bits are ignored until the next start.
- Start in RECV with i≠0:
  - Current frame is abandoned; partial byte discarded.
  - oFrame_err pulse.
  - The start cycle is taken as bit 0 of a new frame; state stays RECV.
- iSerial_start and iSerial_end both high in IDLE: treated as start.
  - If MSG_SIZE>1, this is also an immediate short frame → oFrame_err, → IDLE.
- Index widths: bit counter is $clog2(MSG_SIZE)+1 bits; key index is the counter's low $clog2(KEY_SIZE) bits.

## Timing
- Reset (rst_n=0 at a clock edge) sets:
  - state=IDLE
  - key=0, key count=0
  - oByte=0x00
  - oByte_valid=0, oFrame_done=0, oFrame_err=0
  - oKey_ready=0, oBusy=0
- Reset mid-frame: the frame is lost and no strobes are emitted.
- Latency: 1 cycle from sampling frame bit 8k+7 to oByte_valid. At most one byte every 8 cycles.
- All outputs are registered; there are no combinational input-to-output paths.
- No backpressure: the consumer must accept oByte whenever oByte_valid=1.
- ena=0 stretches the stream. The upstream serializer shares ena, so bits only advance on enabled cycles.
- oBusy rises the cycle after the start is accepted and falls the cycle after the end bit.

## Test plan
- Key 32'h0000_00FF loaded LSB first (32 cycles iLoad_key=1), then a 512-bit all-ones frame with start on bit 0 and end on bit 511.
  - Expect 64 bytes in repeating groups 0x00,0xFF,0xFF,0xFF.
  - oFrame_done with byte 63.
  - No oFrame_err.
- Round trip: random 32-bit key and random 512-bit message through the encryptor, then this block.
  - Expect 64 bytes equal to the message, LSB-byte first.
  - Each oByte_valid exactly 1 cycle after its bit 8k+7.
- Short frame: end asserted on bit 100.
  - Expect 12 bytes, then oFrame_err.
  - No oFrame_done; oBusy=0 the next cycle.
- Start without key: iSerial_start after reset with no key load.
  - Expect oFrame_err, state stays IDLE, no oByte_valid.
- Restart and key freeze:
  - Second iSerial_start at bit 40 → oFrame_err; the next 512 bits decode correctly as a new frame.
  - iLoad_key toggled mid-frame → key unchanged and all bytes correct.
- Overlong and reset:
  - Frame with no end → 64 bytes plus oFrame_err; later bits ignored.
  - rst_n=0 at bit 200 → all outputs 0 the next cycle, and oKey_ready=0.

Source files
------------

// File: rtl/xor_stream_decrypt.sv
// Receive-side XOR stream decryptor: strips a serially loaded repeating key from a
// framed ciphertext bit stream and emits plaintext bytes with frame status strobes.
module xor_stream_decrypt #(
    parameter int KEY_SIZE = 32,
    parameter int MSG_SIZE = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       iKey_bit,
    input  logic       iLoad_key,
    input  logic       iSerial_in,
    input  logic       iSerial_start,
    input  logic       iSerial_end,
    output logic [7:0] oByte,
    output logic       oByte_valid,
    output logic       oFrame_done,
    output logic       oFrame_err,
    output logic       oKey_ready,
    output logic       oBusy
);

    localparam int CW  = $clog2(MSG_SIZE) + 1;
    localparam int KW  = $clog2(KEY_SIZE);
    localparam int KCW = KW + 1;
    localparam bit START_END_IS_SHORT = (MSG_SIZE > 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t              r_state;
    logic [KEY_SIZE-1:0] r_key;
    logic [KCW-1:0]      r_keyCnt;
    logic [CW-1:0]       r_bitCnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_byte;
    logic                r_byteValid;
    logic                r_frameDone;
    logic                r_frameErr;
    logic                r_keyReady;
    logic                r_busy;

    logic [KW-1:0]       w_keyIdx;
    logic                w_plainBit;
    logic                w_firstBit;
    logic [7:0]          w_nextShift;
    logic [7:0]          w_startShift;
    logic                w_lastBit;
    logic                w_byteDone;

    // The key index is simply the low bits of the frame bit counter.
    assign w_keyIdx     = r_bitCnt[KW-1:0];
    assign w_plainBit   = iSerial_in ^ r_key[w_keyIdx];
    assign w_firstBit   = iSerial_in ^ r_key[0];
    assign w_nextShift  = {w_plainBit, r_shift[7:1]};
    assign w_startShift = {w_firstBit, r_shift[7:1]};
    assign w_lastBit    = (r_bitCnt == CW'(MSG_SIZE - 1));
    assign w_byteDone   = (r_bitCnt[2:0] == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_keyCnt    <= '0;
            r_bitCnt    <= '0;
            r_shift     <= 8'h00;
            r_byte      <= 8'h00;
            r_byteValid <= 1'b0;
            r_frameDone <= 1'b0;
            r_frameErr  <= 1'b0;
            r_keyReady  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_byteValid <= 1'b0;
            r_frameDone <= 1'b0;
            r_frameErr  <= 1'b0;
            if (ena) begin
                case (r_state)
                    IDLE: begin
                        if (iLoad_key) begin
                            r_key <= {iKey_bit, r_key[KEY_SIZE-1:1]};
                            if (r_keyCnt != KCW'(KEY_SIZE))
                                r_keyCnt <= r_keyCnt + 1'b1;
                            if (r_keyCnt >= KCW'(KEY_SIZE - 1))
                                r_keyReady <= 1'b1;
                        end
                        if (iSerial_start) begin
                            if (r_keyReady) begin
                                r_shift  <= w_startShift;
                                r_bitCnt <= CW'(1);
                                if (iSerial_end && START_END_IS_SHORT) begin
                                    r_frameErr <= 1'b1;
                                end else begin
                                    r_state <= RECV;
                                    r_busy  <= 1'b1;
                                end
                            end else begin
                                r_frameErr <= 1'b1;
                            end
                        end
                    end
                    RECV: begin
                        if (iSerial_start) begin
                            // Restart: abandon the partial frame, this cycle is bit 0 of a new one.
                            r_frameErr <= 1'b1;
                            r_shift    <= w_startShift;
                            r_bitCnt   <= CW'(1);
                            if (iSerial_end && START_END_IS_SHORT) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_shift  <= w_nextShift;
                            r_bitCnt <= r_bitCnt + 1'b1;
                            if (w_byteDone && (!iSerial_end || w_lastBit)) begin
                                r_byte      <= w_nextShift;
                                r_byteValid <= 1'b1;
                            end
                            if (iSerial_end) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                if (w_lastBit)
                                    r_frameDone <= 1'b1;
                                else
                                    r_frameErr <= 1'b1;
                            end else if (w_lastBit) begin
                                r_state    <= IDLE;
                                r_busy     <= 1'b0;
                                r_frameErr <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign oByte       = r_byte;
    assign oByte_valid = r_byteValid;
    assign oFrame_done = r_frameDone;
    assign oFrame_err  = r_frameErr;
    assign oKey_ready  = r_keyReady;
    assign oBusy       = r_busy;

endmodule
